// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared FSM state type and HD44780 command constants for the LCD bus arbiter
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DELAY = 2'd2,
        ST_ACK   = 2'd3
    } lcdState_t;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_rr_picker.sv
// rtl/lcd_rr_picker.sv - combinational round-robin picker: first set request at or above ptr, with wrap
module lcd_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winOneHot,
    output logic [IDX_W-1:0]   winIdx,
    output logic               winValid
);

    always_comb begin
        winOneHot = '0;
        winIdx    = '0;
        winValid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int cand;
            logic [IDX_W-1:0] candIdx;
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            candIdx = IDX_W'(cand);
            if (!winValid && req[candIdx]) begin
                winValid           = 1'b1;
                winOneHot[candIdx] = 1'b1;
                winIdx             = candIdx;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - round-robin arbiter sharing one LCD_Controller port, with lock and settle delay
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int               NUM_REQ = 2,
    parameter int               DLY_W   = 18,
    parameter logic [DLY_W-1:0] DLY_MAX = 18'h3FFFE
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [NUM_REQ-1:0]   iREQ,
    input  logic [8*NUM_REQ-1:0] iDATA,
    input  logic [NUM_REQ-1:0]   iRS,
    input  logic [NUM_REQ-1:0]   iLOCK,
    output logic [NUM_REQ-1:0]   oGNT,
    output logic [NUM_REQ-1:0]   oACK,
    output logic                 oBUSY,
    output logic [7:0]           oCTL_DATA,
    output logic                 oCTL_RS,
    output logic                 oCTL_START,
    input  logic                 iCTL_DONE
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    lcdState_t          state;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rrPtr;
    logic               lockFlag;
    logic [DLY_W-1:0]   dlyCnt;
    logic [7:0]         ctlData;
    logic               ctlRs;
    logic               ctlStart;

    logic [NUM_REQ-1:0] pkOneHot;
    logic [IDX_W-1:0]   pkIdx;
    logic               pkValid;

    logic               lockHeld;
    logic               lockDrop;
    logic               selValid;
    logic [IDX_W-1:0]   selIdx;
    logic [NUM_REQ-1:0] selOneHot;
    logic [IDX_W-1:0]   nextPtr;

    lcd_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPicker (
        .req       (iREQ),
        .ptr       (rrPtr),
        .winOneHot (pkOneHot),
        .winIdx    (pkIdx),
        .winValid  (pkValid)
    );

    // A held lock narrows arbitration to the owner; a dropped lock falls back to round-robin this cycle.
    assign lockHeld = lockFlag && iLOCK[owner];
    assign lockDrop = lockFlag && !iLOCK[owner];
    assign nextPtr  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    always_comb begin
        selValid  = 1'b0;
        selIdx    = '0;
        selOneHot = '0;
        if (lockHeld) begin
            selValid  = iREQ[owner];
            selIdx    = owner;
            selOneHot = NUM_REQ'(1) << owner;
        end else begin
            selValid  = pkValid;
            selIdx    = pkIdx;
            selOneHot = pkOneHot;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            owner    <= '0;
            rrPtr    <= '0;
            lockFlag <= 1'b0;
            dlyCnt   <= '0;
            ctlData  <= '0;
            ctlRs    <= 1'b0;
            ctlStart <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lockDrop) lockFlag <= 1'b0;
                    if (selValid) begin
                        gnt      <= selOneHot;
                        owner    <= selIdx;
                        ctlData  <= iDATA[{selIdx, 3'b000} +: 8];
                        ctlRs    <= iRS[selIdx];
                        ctlStart <= 1'b1;
                        state    <= ST_START;
                    end else if (lockDrop) begin
                        gnt <= '0;
                    end
                end
                ST_START: begin
                    if (iCTL_DONE) begin
                        ctlStart <= 1'b0;
                        dlyCnt   <= '0;
                        state    <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dlyCnt < DLY_MAX) begin
                        dlyCnt <= dlyCnt + DLY_W'(1);
                    end else begin
                        dlyCnt <= '0;
                        state  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (iLOCK[owner]) begin
                        lockFlag <= 1'b1;
                    end else begin
                        lockFlag <= 1'b0;
                        gnt      <= '0;
                        rrPtr    <= nextPtr;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oGNT       = gnt;
    assign oACK       = (state == ST_ACK) ? gnt : '0;
    assign oBUSY      = (state != ST_IDLE);
    assign oCTL_DATA  = ctlData;
    assign oCTL_RS    = ctlRs;
    assign oCTL_START = ctlStart;

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
Shares one LCD_Controller host port between NUM_REQ independent requesters, such as a boot/init sequencer, a status-text writer and a debug writer. Grants are round-robin per command. An optional lock lets one requester issue a multi-command transaction (for example a cursor move followed by 16 characters) without interleaving. The block owns the LCD_Controller start/done handshake and the mandatory post-command settle delay, so requesters see only a request/grant/ack interface.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DLY_W, 18, width of settle-delay counter
DLY_MAX, 18'h3FFFE, settle-delay terminal count; DELAY lasts DLY_MAX+1 cycles

Ports:
iCLK  in  1  clock
iRST_N  in  1  asynchronous active-low reset
iREQ  in  NUM_REQ  per-requester command request, level
iDATA  in  8*NUM_REQ  command/char byte, requester k at [8k+7:8k]
iRS  in  NUM_REQ  register select: 0 = instruction, 1 = data
iLOCK  in  NUM_REQ  hold the grant after the current command
oGNT  out  NUM_REQ  one-hot grant, 0 when idle
oACK  out  NUM_REQ  one-cycle pulse: command complete including settle delay
oBUSY  out  1  high in any state other than IDLE
oCTL_DATA  out  8  to LCD_Controller iDATA
oCTL_RS  out  1  to LCD_Controller iRS
oCTL_START  out  1  to LCD_Controller iStart
iCTL_DONE  in  1  from LCD_Controller oDone

Behaviour:
- Reset (async, any state): state=IDLE; oGNT=0, oACK=0, oBUSY=0, oCTL_START=0, oCTL_DATA=0, oCTL_RS=0; rr pointer=0; lock flag=0; delay counter=0. A reset mid-command abandons the command with no ack.
- FSM states: IDLE, START, DELAY, ACK.
- IDLE:
  - Unlocked: if any iREQ is set, pick the first set bit searching from the rr pointer upward, with wrap.
  - Locked: consider only the owner's iREQ.
  - On a pick, register oGNT=onehot(winner), and latch oCTL_DATA/oCTL_RS from the winner's slice.
  - Set oCTL_START=1 and go to START. Request-to-start latency is 1 cycle.
  - If locked and the owner's iLOCK=0 while in IDLE: clear the lock and arbitrate normally in the same cycle.
- START: hold oCTL_START=1 until iCTL_DONE=1. On that edge, oCTL_START<=0, counter<=0, go to DELAY.
- DELAY: counter increments while counter<DLY_MAX. At DLY_MAX, clear the counter and go to ACK.
- ACK:
  - oACK[owner]=1 for exactly this cycle.
  - If iLOCK[owner]=1: set the lock flag and keep oGNT.
  - Otherwise: oGNT<=0 and rr pointer<=(owner+1) mod NUM_REQ.
  - Go to IDLE.
- Requester contract:
  - Hold iDATA/iRS stable from iREQ rise until the grant cycle. Only the grant-cycle values are latched.
  - In the oACK cycle, present the next command. Holding iREQ high gives back-to-back commands.
- iREQ dropped after grant: the command still completes and acks.
- iCTL_DONE outside START: ignored.
- Simultaneous requests: only one winner per IDLE cycle. Losers wait without an ack; no request is lost while iREQ stays high.
- While the lock is held, other requesters are starved. This is intentional; lock length is bounded by requester design.
- Minimum command period: 1 (IDLE) + START duration + (DLY_MAX+1) + 1 (ACK) cycles.
- oCTL_DATA/oCTL_RS hold the last command's values when idle.

Decomposition:
- Shared package lcd_pkg:
  - FSM state enum.
  - LCD instruction constants: FUNC_SET=8'h38, DISP_ON=8'h0C, CLEAR=8'h01, ENTRY=8'h06, LINE1=8'h80, LINE2=8'hC0.
  - RS_CMD=0, RS_DATA=1.
- Sub-module lcd_rr_picker: combinational, parameterised NUM_REQ. Inputs: req vector and pointer. Outputs: one-hot winner and index.

Test Plan:
Settings for all scenarios: NUM_REQ=2, DLY_MAX=4, controller model asserts iCTL_DONE 3 cycles after iCTL_START rises.
1. Single request: iREQ=01, iDATA[7:0]=8'h38, iRS=0 -> next cycle oGNT=01, oCTL_START=1, oCTL_DATA=8'h38; START lasts 3 cycles, DELAY 5 cycles, then oACK=01 for 1 cycle; oGNT=0 after.
2. Simultaneous requests, iREQ=11 held -> serviced 0,1,0,1 alternately; each oACK matches the granted bit; oCTL_DATA tracks the granted slice.
3. Lock: req0 sends 8'h80 then 16 chars with iLOCK[0]=1 while iREQ[1] is held -> 17 consecutive acks to req0, none to req1; iLOCK[0]=0 -> req1 granted next IDLE.
4. Reset asserted mid-DELAY -> all outputs 0 immediately, no oACK; after release, a pending iREQ=10 is granted to req1 (pointer reset 0, req0 idle).
5. Spurious iCTL_DONE pulse in IDLE and DELAY -> no state change, DELAY still lasts exactly 5 cycles.
6. req1 drops iREQ one cycle after grant -> command completes, oACK=10 still pulses, then idle.
